decw_init_sequencer: RTL and testbench

DECW_INIT_SEQUENCER -- requirements
Module: decw_init_sequencer

---
 rtl/decw_init_sequencer_pkg.sv | 22 ++
 rtl/decw_init_sequencer_timeout_cnt.sv | 30 +++
 rtl/decw_init_sequencer.sv | 119 +++++++++++
 tb/tb_decw_init_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decw_init_sequencer_pkg.sv
// Shared decoder constants for the init sequencer: state encoding, index width
// and the one-hot launch helper.
package decw_init_sequencer_pkg;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned MAX_SUB = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } seqState_e;

    function automatic logic [MAX_SUB-1:0] idxOneHot(input logic [IDX_W-1:0] idx);
        return MAX_SUB'(1) << idx;
    endfunction

endpackage

// File: rtl/decw_init_sequencer_timeout_cnt.sv
// Per-run timeout counter: cleared on launch, counts while waiting, flags the
// cycle in which the count reaches its final allowed value.
module seq_timeout_cnt
    import decw_init_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic termCnt_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High when this cycle's increment brings the count to TIMEOUT-1.
    assign termCnt_c = enable && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/decw_init_sequencer.sv
// Launches enabled init sub-FSMs one at a time in ascending order, waiting for
// each done level, and stops with an error on a per-run timeout.
module decw_init_sequencer
    import decw_init_sequencer_pkg::*;
#(
    parameter int unsigned N_SUB   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_SUB-1:0] en_mask,
    output logic [N_SUB-1:0] sub_start,
    input  logic [N_SUB-1:0] sub_done,
    output logic             busy,
    output logic [IDX_W-1:0] cur_idx,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SUB - 1);

    seqState_e          state;
    logic [MAX_SUB-1:0] maskR;
    logic [IDX_W-1:0]   idxR;
    logic [MAX_SUB-1:0] doneExt;
    logic               cntClear;
    logic               cntEnable;
    logic               timeoutHit_c;

    // Widen to the full index range so a 3-bit index selects cleanly.
    assign doneExt   = MAX_SUB'(sub_done);
    assign cntClear  = (state == ST_LAUNCH);
    assign cntEnable = (state == ST_WAIT);

    seq_timeout_cnt #(
        .LIMIT (TIMEOUT - 2)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear     (cntClear),
        .enable    (cntEnable),
        .termCnt_c (timeoutHit_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            maskR     <= '0;
            idxR      <= '0;
            sub_start <= '0;
            busy      <= 1'b0;
            cur_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
        end else begin
            sub_start <= '0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        maskR   <= MAX_SUB'(en_mask);
                        idxR    <= '0;
                        cur_idx <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        err_idx <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (maskR[idxR]) begin
                        sub_start <= N_SUB'(idxOneHot(idxR));
                        state     <= ST_LAUNCH;
                    end else if (idxR == LAST_IDX) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cur_idx <= '0;
                        state   <= ST_DONE;
                    end else begin
                        idxR    <= idxR + IDX_W'(1);
                        cur_idx <= idxR + IDX_W'(1);
                    end
                end
                // Done levels are not looked at here, so a stale level cannot complete a run.
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (doneExt[idxR]) begin
                        if (idxR == LAST_IDX) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cur_idx <= '0;
                            state   <= ST_DONE;
                        end else begin
                            idxR    <= idxR + IDX_W'(1);
                            cur_idx <= idxR + IDX_W'(1);
                            state   <= ST_SCAN;
                        end
                    end else if (timeoutHit_c) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        err_idx <= idxR;
                        cur_idx <= '0;
                        state   <= ST_ERR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decw_init_sequencer.sv
// Scoreboard bench for decw_init_sequencer: a timeline model predicts launch and
// completion cycles, a reactive sub-FSM responder drives done levels.
module tb_decw_init_sequencer;

    localparam int N_SUB   = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 100;

    typedef struct {
        int kind;     // 0 = launch pulse, 1 = sequence end
        int idx;
        int cyc;
        int errFlag;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [N_SUB-1:0] en_mask;
    logic [N_SUB-1:0] sub_start;
    logic [N_SUB-1:0] sub_done;
    logic             busy;
    logic [2:0]       cur_idx;
    logic             done;
    logic             err;
    logic [2:0]       err_idx;

    decw_init_sequencer #(
        .N_SUB   (N_SUB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .en_mask   (en_mask),
        .sub_start (sub_start),
        .sub_done  (sub_done),
        .busy      (busy),
        .cur_idx   (cur_idx),
        .done      (done),
        .err       (err),
        .err_idx   (err_idx)
    );

    int   cyc;
    int   checks;
    int   errors;
    exp_t expQ[$];
    int   dlyCfg[N_SUB];
    int   riseAt[N_SUB];
    logic [N_SUB-1:0] activeMask;
    int   cfgGen;
    int   seenGen;
    int   finCnt;
    int   lastPulse;
    logic prevDone;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline from the sequencing rules: SCAN one cycle per index, LAUNCH one
    // cycle, completion when done is seen in WAIT, error TIMEOUT cycles after launch.
    task automatic pushModel(input int t, input logic [N_SUB-1:0] m);
        int p;
        int eff;
        int l;
        exp_t e;
        p = t + 1;
        for (int i = 0; i < N_SUB; i++) begin
            if (m[i]) begin
                l = p + 1;
                e = '{0, i, l, 0};
                expQ.push_back(e);
                eff = (dlyCfg[i] == 0) ? 1 : dlyCfg[i];
                if (eff <= TIMEOUT - 1) begin
                    p = l + eff + 1;
                end else begin
                    e = '{1, i, l + TIMEOUT, 1};
                    expQ.push_back(e);
                    return;
                end
            end else begin
                p = p + 1;
            end
        end
        e = '{1, 0, p, 0};
        expQ.push_back(e);
    endtask

    task automatic launchSeq(input logic [N_SUB-1:0] m, input bit poke);
        activeMask = m;
        cfgGen     = cfgGen + 1;
        en_mask    = m;
        start      = 1'b1;
        pushModel(cyc, m);
        @(negedge clk);
        start   = 1'b0;
        en_mask = N_SUB'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, required 1 (cyc %0d)", busy, cyc);
        end
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic waitFinish();
        int base;
        int n;
        base = finCnt;
        n    = 0;
        while (finCnt == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (finCnt == base) begin
            checks++;
            errors++;
            $display("FAIL seq_timeout: got no done within 300 cycles, required done (cyc %0d)", cyc);
            expQ.delete();
        end
    endtask

    task automatic runSeq(input logic [N_SUB-1:0] m, input bit poke);
        launchSeq(m, poke);
        waitFinish();
    endtask

    task automatic setDly(input int d0, input int d1, input int d2, input int d3);
        dlyCfg[0] = d0;
        dlyCfg[1] = d1;
        dlyCfg[2] = d2;
        dlyCfg[3] = d3;
    endtask

    function automatic int pickDly();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return 0;
            1:       return TIMEOUT - 1;
            2:       return TIMEOUT;
            3:       return NEVER;
            default: return int'($urandom_range(1, TIMEOUT - 2));
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [N_SUB-1:0] sd;
        logic [N_SUB-1:0] m;
        int n;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        cfgGen     = 0;
        seenGen    = 0;
        finCnt     = 0;
        lastPulse  = -1;
        prevDone   = 1'b0;
        activeMask = '0;
        reset      = 1'b0;
        start      = 1'b0;
        en_mask    = '0;
        sub_done   = '0;
        setDly(1, 1, 1, 1);
        for (int i = 0; i < N_SUB; i++) riseAt[i] = 32'h7fffffff;
        fork
            // Monitor/scoreboard plus reactive sub-FSM done responder.
            forever begin
                @(negedge clk);
                if (sub_start != '0) begin
                    checks++;
                    for (int i = 0; i < N_SUB; i++) if (sub_start[i]) lastPulse = i;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse: got sub_start %b at cyc %0d, required none", sub_start, cyc);
                    end else begin
                        e = expQ.pop_front();
                        if (e.kind != 0 || sub_start !== N_SUB'(1 << e.idx) ||
                            cur_idx !== 3'(e.idx) || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL pulse: got sub_start %b cur_idx %0d cyc %0d, required kind 0 idx %0d cyc %0d (kind %0d)",
                                     sub_start, cur_idx, cyc, e.idx, e.cyc, e.kind);
                        end
                    end
                end
                if (done === 1'b1 && prevDone !== 1'b1) begin
                    checks++;
                    finCnt++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: got done at cyc %0d, required none", cyc);
                    end else begin
                        e = expQ.pop_front();
                        if (e.kind != 1 || err !== e.errFlag[0] || err_idx !== 3'(e.idx) ||
                            cyc != e.cyc || busy !== 1'b0 || cur_idx !== 3'd0) begin
                            errors++;
                            $display("FAIL finish: got err %b err_idx %0d cyc %0d busy %b cur_idx %0d, required kind 1 err %0d err_idx %0d cyc %0d busy 0 cur_idx 0 (kind %0d)",
                                     err, err_idx, cyc, busy, cur_idx, e.errFlag, e.idx, e.cyc, e.kind);
                        end
                    end
                end
                prevDone = done;
                if (cfgGen != seenGen) begin
                    seenGen = cfgGen;
                    for (int i = 0; i < N_SUB; i++) riseAt[i] = 32'h7fffffff;
                end
                for (int i = 0; i < N_SUB; i++) if (sub_start[i]) riseAt[i] = cyc + dlyCfg[i];
                for (int i = 0; i < N_SUB; i++) begin
                    sd[i] = (dlyCfg[i] == 0) || (cyc >= riseAt[i]) ||
                            (!activeMask[i] && ($urandom_range(0, 1) == 1));
                end
                sub_done = sd;
            end
            begin
                repeat (3) @(negedge clk);
                checks++;
                if ({sub_start, busy, cur_idx, done, err, err_idx} !== '0) begin
                    errors++;
                    $display("FAIL reset_state: got sub_start %b busy %b cur_idx %0d done %b err %b err_idx %0d, required all 0",
                             sub_start, busy, cur_idx, done, err, err_idx);
                end
                reset = 1'b1;
                @(negedge clk);

                setDly(10, 10, 10, 10);
                runSeq(4'b1111, 1'b0);
                setDly(5, 3, 7, 2);
                runSeq(4'b0101, 1'b0);
                setDly(3, NEVER, 4, 4);
                runSeq(4'b1111, 1'b0);
                setDly(0, 2, 2, 2);
                runSeq(4'b1111, 1'b1);
                setDly(1, 1, 1, 1);
                runSeq(4'b0000, 1'b0);
                setDly(2, TIMEOUT - 1, 1, TIMEOUT);
                runSeq(4'b1011, 1'b1);

                // Asynchronous reset while waiting on sub 2.
                setDly(2, 2, 30, 2);
                lastPulse = -1;
                launchSeq(4'b1111, 1'b0);
                n = 0;
                while (lastPulse != 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3) @(negedge clk);
                #1 reset = 1'b0;
                #1;
                checks++;
                if (lastPulse != 2 || {sub_start, busy, cur_idx, done, err, err_idx} !== '0) begin
                    errors++;
                    $display("FAIL async_reset: got lastPulse %0d sub_start %b busy %b cur_idx %0d done %b err %b err_idx %0d, required pulse 2 then all 0",
                             lastPulse, sub_start, busy, cur_idx, done, err, err_idx);
                end
                expQ.delete();
                repeat (2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                setDly(3, 3, 3, 3);
                runSeq(4'b1111, 1'b0);

                for (int s = 0; s < 40; s++) begin
                    for (int i = 0; i < N_SUB; i++) dlyCfg[i] = pickDly();
                    m = N_SUB'($urandom);
                    runSeq(m, ($urandom_range(0, 1) == 1));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end

                repeat (5) @(negedge clk);
                checks++;
                if (expQ.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_expect: got %0d pending events, required 0", expQ.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
